// File: rtl/chip8_framebuffer.sv
// CHIP-8 64x32 monochrome framebuffer with XOR sprite-byte draw and clear.
// Single command port, registered display read port with read-before-write.
module chip8_framebuffer #(
    parameter int CLIP = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_op,
    input  logic [5:0]  cmd_x,
    input  logic [4:0]  cmd_y,
    input  logic [7:0]  cmd_data,
    output logic        done,
    output logic        collision,
    input  logic [4:0]  disp_row,
    output logic [63:0] disp_data
);

    typedef enum logic [1:0] {
        IDLE,
        DRAW_RD,
        DRAW_WR,
        CLEAR
    } state_t;

    state_t state, state_n;

    logic [63:0] mem [32];
    logic [4:0]  cnt;
    logic        clr_cmd;
    logic [5:0]  cx;
    logic [4:0]  cy;
    logic [7:0]  cd;
    logic [63:0] rd_row;
    logic [63:0] mask;
    logic [6:0]  col;
    logic        accept;
    logic        mem_we;
    logic [4:0]  mem_wa;
    logic [63:0] mem_wd;
    logic        fin;
    logic        fin_col;

    // Sprite mask: bit 7 of the byte lands on column x, wrapping or clipped.
    always_comb begin
        mask = '0;
        col  = '0;
        for (int k = 0; k < 8; k++) begin
            col = {1'b0, cx} + 7'(7 - k);
            if (!((CLIP != 0) && col[6])) begin
                mask[col[5:0]] = cd[k];
            end
        end
    end

    // State register; reset always restarts the screen clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= CLEAR;
        end else begin
            state <= state_n;
        end
    end

    // Next-state, handshake, RAM write and completion decode.
    always_comb begin
        state_n   = state;
        cmd_ready = 1'b0;
        accept    = 1'b0;
        mem_we    = 1'b0;
        mem_wa    = cy;
        mem_wd    = rd_row ^ mask;
        fin       = 1'b0;
        fin_col   = 1'b0;
        unique case (state)
            IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    accept  = 1'b1;
                    state_n = cmd_op ? CLEAR : DRAW_RD;
                end
            end
            DRAW_RD: begin
                state_n = DRAW_WR;
            end
            DRAW_WR: begin
                mem_we  = 1'b1;
                fin     = 1'b1;
                fin_col = |(rd_row & mask);
                state_n = IDLE;
            end
            CLEAR: begin
                mem_we = 1'b1;
                mem_wa = cnt;
                mem_wd = '0;
                if (cnt == 5'd31) begin
                    state_n = IDLE;
                    fin     = clr_cmd;
                end
            end
            default: state_n = CLEAR;
        endcase
    end

    // Command capture, clear row counter, row fetch and result flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt       <= '0;
            clr_cmd   <= 1'b0;
            cx        <= '0;
            cy        <= '0;
            cd        <= '0;
            rd_row    <= '0;
            done      <= 1'b0;
            collision <= 1'b0;
        end else begin
            done <= fin;
            if (fin) begin
                collision <= fin_col;
            end
            if (accept) begin
                cx      <= cmd_x;
                cy      <= cmd_y;
                cd      <= cmd_data;
                clr_cmd <= cmd_op;
                cnt     <= '0;
            end
            if (state == CLEAR) begin
                cnt <= cnt + 5'd1;
            end
            if (state == DRAW_RD) begin
                rd_row <= mem[cy];
            end
        end
    end

    // Pixel RAM write port; a reset cycle never commits a write.
    always_ff @(posedge clk) begin
        if (mem_we && !reset) begin
            mem[mem_wa] <= mem_wd;
        end
    end

    // Display read port, sampled every cycle (old data on collision).
    always_ff @(posedge clk) begin
        if (reset) begin
            disp_data <= '0;
        end else begin
            disp_data <= mem[disp_row];
        end
    end

endmodule

// File: tb/tb_chip8_framebuffer.sv
// Self-checking bench for chip8_framebuffer, CLIP=0 and CLIP=1 side by side.
// Table vectors, hand sequences and random commands against a pixel model.
module tb_chip8_framebuffer;

    logic        clk;
    logic        reset;
    logic        cmd_valid;
    logic        cmd_op;
    logic [5:0]  cmd_x;
    logic [4:0]  cmd_y;
    logic [7:0]  cmd_data;
    logic [4:0]  disp_row;
    logic        cmd_ready0, cmd_ready1;
    logic        done0, done1;
    logic        collision0, collision1;
    logic [63:0] disp_data0, disp_data1;

    int errors = 0;
    int checks = 0;

    logic [63:0] mrow [2][32];

    chip8_framebuffer #(.CLIP(0)) dut0 (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready0), .cmd_op(cmd_op), .cmd_x(cmd_x),
        .cmd_y(cmd_y), .cmd_data(cmd_data), .done(done0),
        .collision(collision0), .disp_row(disp_row),
        .disp_data(disp_data0)
    );

    chip8_framebuffer #(.CLIP(1)) dut1 (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready1), .cmd_op(cmd_op), .cmd_x(cmd_x),
        .cmd_y(cmd_y), .cmd_data(cmd_data), .done(done1),
        .collision(collision1), .disp_row(disp_row),
        .disp_data(disp_data1)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    typedef struct {
        bit          op;
        logic [5:0]  x;
        logic [4:0]  y;
        logic [7:0]  d;
        bit          c0;
        bit          c1;
        logic [63:0] r0;
        logic [63:0] r1;
    } tv_t;

    tv_t tv [6];

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic m_clear();
        for (int c = 0; c < 2; c++)
            for (int r = 0; r < 32; r++)
                mrow[c][r] = '0;
    endtask

    // Pixel-by-pixel XOR draw: pixel i of the byte goes to column x+i.
    task automatic m_draw(input int c, input int x, input int y,
                          input logic [7:0] d, output bit coll);
        int cl;
        coll = 0;
        for (int i = 0; i < 8; i++) begin
            cl = x + i;
            if (d[7-i] && !(c == 1 && cl > 63)) begin
                cl = cl % 64;
                if (mrow[c][y][cl]) coll = 1;
                mrow[c][y][cl] = ~mrow[c][y][cl];
            end
        end
    endtask

    task automatic read_row(input int r, output logic [63:0] d0,
                            output logic [63:0] d1);
        disp_row = 5'(r);
        tick();
        d0 = disp_data0;
        d1 = disp_data1;
    endtask

    task automatic check_all(input string name);
        logic [63:0] d0, d1;
        for (int r = 0; r < 32; r++) begin
            read_row(r, d0, d1);
            chk($sformatf("%s_row%0d_clip0", name, r), d0, mrow[0][r]);
            chk($sformatf("%s_row%0d_clip1", name, r), d1, mrow[1][r]);
        end
    endtask

    // Issue one command from IDLE; returns cycles to done, flags, and
    // the display word seen on the done cycle (row y, pre-write).
    task automatic issue(input bit op, input logic [5:0] x,
                         input logic [4:0] y, input logic [7:0] d,
                         input bit poke, output int lat,
                         output logic c0, output logic c1,
                         output logic [63:0] pre0);
        bit e0, e1;
        chk("ready_before_cmd", {cmd_ready0, cmd_ready1}, 2'b11);
        disp_row  = y;
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_x     = x;
        cmd_y     = y;
        cmd_data  = d;
        tick();
        cmd_valid = 1'b0;
        lat = 1;
        while (!done0 && lat < 40) begin
            if (poke && lat >= 3 && lat < 10) begin
                cmd_valid = 1'b1;
                cmd_op    = 1'b0;
                cmd_x     = 6'($urandom);
                cmd_y     = 5'($urandom);
                cmd_data  = 8'hFF;
            end else begin
                cmd_valid = 1'b0;
            end
            tick();
            lat++;
        end
        cmd_valid = 1'b0;
        chk("done_clip1", done1, 1'b1);
        c0   = collision0;
        c1   = collision1;
        pre0 = disp_data0;
        if (op) begin
            m_clear();
        end else begin
            m_draw(0, int'(x), int'(y), d, e0);
            m_draw(1, int'(x), int'(y), d, e1);
        end
    endtask

    task automatic wait_clear_after_reset(input string name);
        int  n;
        bit  seen;
        n    = 0;
        seen = 0;
        while (!cmd_ready0 && n < 40) begin
            tick();
            n++;
            if (done0 || done1) seen = 1;
        end
        chk({name, "_ready_low_cycles"}, 64'(n), 64'd32);
        chk({name, "_ready_clip1"}, cmd_ready1, 1'b1);
        chk({name, "_no_done"}, seen, 1'b0);
    endtask

    task automatic reset_outputs(input string name);
        chk({name, "_done"}, {done0, done1}, 2'b00);
        chk({name, "_collision"}, {collision0, collision1}, 2'b00);
        chk({name, "_ready"}, {cmd_ready0, cmd_ready1}, 2'b00);
        chk({name, "_disp0"}, disp_data0, 64'h0);
        chk({name, "_disp1"}, disp_data1, 64'h0);
    endtask

    initial begin
        int          lat, n;
        logic        c0, c1;
        logic [63:0] pre0, snap, d0, d1;
        bit          e0, e1;
        logic [5:0]  nx;
        logic [4:0]  ny;
        logic [7:0]  nd;
        bit          op;

        tv[0] = '{0, 6'd0,  5'd0,  8'hF0, 0, 0,
                  64'h000000000000000F, 64'h000000000000000F};
        tv[1] = '{0, 6'd0,  5'd0,  8'hF0, 1, 1, 64'h0, 64'h0};
        tv[2] = '{0, 6'd60, 5'd31, 8'hFF, 0, 0,
                  64'hF00000000000000F, 64'hF000000000000000};
        tv[3] = '{0, 6'd62, 5'd31, 8'hC3, 1, 1,
                  64'h300000000000003F, 64'h3000000000000000};
        tv[4] = '{0, 6'd10, 5'd5,  8'h81, 0, 0,
                  64'h0000000000020400, 64'h0000000000020400};
        tv[5] = '{1, 6'd0,  5'd31, 8'h00, 0, 0, 64'h0, 64'h0};

        reset     = 1'b1;
        cmd_valid = 1'b0;
        cmd_op    = 1'b0;
        cmd_x     = '0;
        cmd_y     = '0;
        cmd_data  = '0;
        disp_row  = '0;
        m_clear();

        repeat (3) tick();
        reset_outputs("reset");
        reset = 1'b0;
        wait_clear_after_reset("por");
        check_all("por");

        for (int i = 0; i < 6; i++) begin
            snap = mrow[0][tv[i].y];
            issue(tv[i].op, tv[i].x, tv[i].y, tv[i].d, tv[i].op,
                  lat, c0, c1, pre0);
            chk($sformatf("tv%0d_latency", i), 64'(lat),
                tv[i].op ? 64'd33 : 64'd3);
            chk($sformatf("tv%0d_coll0", i), c0, tv[i].c0);
            chk($sformatf("tv%0d_coll1", i), c1, tv[i].c1);
            chk($sformatf("tv%0d_prewrite", i), pre0, snap);
            tick();
            chk($sformatf("tv%0d_done_pulse", i), {done0, done1}, 2'b00);
            read_row(int'(tv[i].y), d0, d1);
            chk($sformatf("tv%0d_row_clip0", i), d0, tv[i].r0);
            chk($sformatf("tv%0d_row_clip1", i), d1, tv[i].r1);
        end
        check_all("after_clear");

        cmd_valid = 1'b1;
        cmd_op    = 1'b0;
        cmd_x     = 6'($urandom);
        cmd_y     = 5'($urandom);
        cmd_data  = 8'($urandom);
        tick();
        for (int j = 0; j < 5; j++) begin
            m_draw(0, int'(cmd_x), int'(cmd_y), cmd_data, e0);
            m_draw(1, int'(cmd_x), int'(cmd_y), cmd_data, e1);
            nx = 6'($urandom);
            ny = 5'($urandom_range(0, 3));
            nd = 8'($urandom);
            if (j < 4) begin
                cmd_x    = nx;
                cmd_y    = ny;
                cmd_data = nd;
            end else begin
                cmd_valid = 1'b0;
            end
            n = 1;
            while (!done0 && n < 10) begin
                tick();
                n++;
            end
            chk($sformatf("b2b%0d_latency", j), 64'(n), 64'd3);
            chk($sformatf("b2b%0d_coll0", j), collision0, e0);
            chk($sformatf("b2b%0d_coll1", j), collision1, e1);
            if (j < 4) begin
                chk($sformatf("b2b%0d_ready", j), cmd_ready0, 1'b1);
                tick();
            end
        end
        tick();
        check_all("b2b");

        issue(0, 6'd0, 6'd0, 8'hF0, 0, lat, c0, c1, pre0);
        tick();
        issue(0, 6'd0, 6'd0, 8'hF0, 0, lat, c0, c1, pre0);
        chk("pre_abort_coll", {c0, c1}, 2'b11);
        tick();
        cmd_valid = 1'b1;
        cmd_op    = 1'b0;
        cmd_x     = 6'd8;
        cmd_y     = 5'd1;
        cmd_data  = 8'hFF;
        tick();
        cmd_valid = 1'b0;
        reset     = 1'b1;
        tick();
        reset_outputs("abort");
        reset = 1'b0;
        m_clear();
        wait_clear_after_reset("abort");
        check_all("abort");

        for (int i = 0; i < 30; i++) begin
            op = ($urandom_range(0, 7) == 0);
            nx = 6'($urandom);
            ny = 5'($urandom_range(0, 7));
            nd = 8'($urandom);
            e0 = 0;
            e1 = 0;
            if (!op) begin
                snap = mrow[0][ny];
                for (int k = 0; k < 8; k++) begin
                    if (nd[7-k]) begin
                        if (mrow[0][ny][(int'(nx) + k) % 64]) e0 = 1;
                        if (int'(nx) + k < 64 && mrow[1][ny][int'(nx) + k])
                            e1 = 1;
                    end
                end
            end
            issue(op, nx, ny, nd, 0, lat, c0, c1, pre0);
            chk($sformatf("rnd%0d_latency", i), 64'(lat),
                op ? 64'd33 : 64'd3);
            chk($sformatf("rnd%0d_coll0", i), c0, e0);
            chk($sformatf("rnd%0d_coll1", i), c1, e1);
        end
        tick();
        check_all("rnd");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/chip8_framebuffer.md
CHIP8_FRAMEBUFFER -- requirements
Module: chip8_framebuffer

Interface
REQ-001 SHALL have parameter CLIP, default 0, meaning 0 = sprite columns wrap mod 64, 1 = columns >63 dropped.
REQ-002 SHALL have port clk  input  1  system clock (50 MHz), sole clock.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port cmd_valid  input  1  command request.
REQ-005 SHALL have port cmd_ready  output  1  block can accept a command this cycle.
REQ-006 SHALL have port cmd_op  input  1  0 = draw sprite byte, 1 = clear screen.
REQ-007 SHALL have port cmd_x  input  6  draw start column 0..63.
REQ-008 SHALL have port cmd_y  input  5  draw row 0..31.
REQ-009 SHALL have port cmd_data  input  8  sprite byte; bit 7 = leftmost pixel.
REQ-010 SHALL have port done  output  1  one-cycle pulse when an accepted command completes.
REQ-011 SHALL have port collision  output  1  result of the last completed command.
REQ-012 SHALL have port disp_row  input  5  display read row 0..31.
REQ-013 SHALL have port disp_data  output  64  pixel row; bit i = column i.

Function
REQ-014 SHALL store 32 rows x 64 bits of pixel state; 1 = lit.
REQ-015 SHALL accept a command only on a cycle with cmd_valid && cmd_ready; cmd_op/x/y/data captured that cycle.
REQ-016 SHALL implement states IDLE, DRAW_RD, DRAW_WR, CLEAR; cmd_ready = 1 only in IDLE.
REQ-017 SHALL transition IDLE->DRAW_RD on accepted draw, DRAW_RD->DRAW_WR, DRAW_WR->IDLE.
REQ-018 SHALL in DRAW_RD fetch row cmd_y; in DRAW_WR write row XOR mask, mask bit ((x+7-k) mod 64) = cmd_data[k].
REQ-019 SHALL when CLIP=1 zero mask bits whose unwrapped column x+7-k exceeds 63.
REQ-020 SHALL compute draw collision = |(old_row & mask).
REQ-021 SHALL transition IDLE->CLEAR on accepted clear, zero one row per cycle in order 0..31, then IDLE.
REQ-022 SHALL give draw latency: accept T, DRAW_RD T+1, DRAW_WR T+2, done and cmd_ready high T+3.
REQ-023 SHALL give clear latency: accept T, rows cleared T+1..T+32, done and cmd_ready high T+33.
REQ-024 SHALL update collision register on the done cycle (0 after clear) and hold it until the next done.
REQ-025 SHALL permit a new command accepted in the same cycle done is high (back-to-back, no bubble).
REQ-026 SHALL register disp_data = row disp_row with 1-cycle latency, reading every cycle regardless of state.
REQ-027 SHALL return pre-write data on disp_data when disp_row equals the row being written in that cycle.
REQ-028 SHALL ignore cmd_valid while cmd_ready = 0; inputs need not be held.

Reset
REQ-029 SHALL on reset force done = 0, collision = 0, cmd_ready = 0, disp_data = 0, state CLEAR at row 0.
REQ-030 SHALL after reset deassertion run the CLEAR sequence (32 cycles) without a done pulse, then enter IDLE.
REQ-031 SHALL on reset mid-command abort it, emit no done, and restart the reset CLEAR sequence.

Verification
REQ-032 SHALL bench reset release -> cmd_ready low 32 cycles, then high; no done; all disp_data rows = 0.
REQ-033 SHALL bench draw x=0 y=0 data=8'hF0 -> done at T+3, collision 0; row0 = 64'h0F.
REQ-034 SHALL bench repeat same draw -> collision 1, row0 = 0.
REQ-035 SHALL bench draw x=60 y=31 data=8'hFF, CLIP=0 -> row31 bits 60..63 and 0..3 set; CLIP=1 -> bits 60..63 only.
REQ-036 SHALL bench clear after draws -> done at T+33, collision 0, all rows 0; cmd_valid mid-clear ignored.
REQ-037 SHALL bench back-to-back draws with cmd_valid held high, plus reset asserted in DRAW_RD -> accepts on done cycles, aborted draw leaves no done and no pixel change.
